// File: rtl/pid_gain_tuner.sv
// Runtime PID gain registers with button-driven fine/coarse tuning.
// Holding an adjust button auto-repeats; editing freezes while locked.
module pid_gain_tuner #(
  parameter int GAIN_WIDTH   = 16,
  parameter int STEP_FINE    = 10,
  parameter int STEP_COARSE  = 100,
  parameter int KP_INIT      = 0,
  parameter int KI_INIT      = 0,
  parameter int KD_INIT      = 0,
  parameter int REPEAT_DELAY = 62500000,
  parameter int REPEAT_RATE  = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_inc_fine,
  input  logic                  btn_inc_coarse,
  input  logic                  btn_dec_fine,
  input  logic                  btn_dec_coarse,
  input  logic                  btn_sel,
  input  logic                  lock,
  output logic [GAIN_WIDTH-1:0] k_p,
  output logic [GAIN_WIDTH-1:0] k_i,
  output logic [GAIN_WIDTH-1:0] k_d,
  output logic [1:0]            sel,
  output logic                  gain_updated
);

  localparam int GW = GAIN_WIDTH;
  localparam logic [31:0] DLY = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE = 32'(REPEAT_RATE - 1);
  localparam logic [GW:0] FINE_W = (GW+1)'(STEP_FINE);
  localparam logic [GW:0] COARSE_W = (GW+1)'(STEP_COARSE);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_WAIT,
    REPEAT
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  btn, btn_q, rise;
  logic [31:0] cnt, cnt_nxt;
  logic [1:0]  act, act_nxt;
  logic [1:0]  step_idx;
  logic        step_en, sel_adv;
  logic [GW-1:0] cur, nv;
  logic [GW:0] wide, mag;

  // Bit order doubles as step index: bit0 = coarse, bit1 = decrement.
  assign btn = {btn_sel, btn_dec_coarse, btn_dec_fine,
                btn_inc_coarse, btn_inc_fine};
  assign rise = btn & ~btn_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_nxt   = act;
    step_en   = 1'b0;
    sel_adv   = 1'b0;
    step_idx  = act;
    unique case (state)
      IDLE: begin
        if (!lock) begin
          if (|rise[3:0]) begin
            if (rise[0])      step_idx = 2'd0;
            else if (rise[1]) step_idx = 2'd1;
            else if (rise[2]) step_idx = 2'd2;
            else              step_idx = 2'd3;
            step_en   = 1'b1;
            act_nxt   = step_idx;
            cnt_nxt   = DLY;
            state_nxt = HOLD_WAIT;
          end else if (rise[4]) begin
            sel_adv = 1'b1;
          end
        end
      end
      HOLD_WAIT, REPEAT: begin
        if (lock || !btn[act]) begin
          state_nxt = IDLE;
        end else if (cnt == 32'd0) begin
          step_en   = 1'b1;
          cnt_nxt   = RATE;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unique case (sel)
      2'd1:    cur = k_i;
      2'd2:    cur = k_d;
      default: cur = k_p;
    endcase
    mag = step_idx[0] ? COARSE_W : FINE_W;
    if (step_idx[1]) begin
      wide = {1'b0, cur} - mag;
      nv   = wide[GW] ? '0 : wide[GW-1:0];
    end else begin
      wide = {1'b0, cur} + mag;
      nv   = wide[GW] ? '1 : wide[GW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_p          <= GW'(KP_INIT);
      k_i          <= GW'(KI_INIT);
      k_d          <= GW'(KD_INIT);
      sel          <= 2'd0;
      gain_updated <= 1'b0;
      state        <= IDLE;
      cnt          <= 32'd0;
      act          <= 2'd0;
      btn_q        <= 5'd0;
    end else begin
      btn_q        <= btn;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      act          <= act_nxt;
      gain_updated <= step_en && (nv != cur);
      if (step_en) begin
        unique case (sel)
          2'd1:    k_i <= nv;
          2'd2:    k_d <= nv;
          default: k_p <= nv;
        endcase
      end
      if (sel_adv) sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end
  end

endmodule

// File: tb/tb_pid_gain_tuner.sv
// Scoreboard bench for pid_gain_tuner: per-cycle reference model
// feeds an expectation queue drained by an independent monitor.
module tb_pid_gain_tuner;
  localparam int DLY  = 8;
  localparam int RATE = 4;
  localparam int MAXG = 65535;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lock = 1'b0;
  logic [4:0] btn = 5'd0;
  logic [15:0] k_p, k_i, k_d;
  logic [1:0] sel;
  logic gain_updated;

  int errors = 0;
  int checks = 0;

  logic [50:0] sbq[$];

  int m_g[3];
  int m_sel, m_act, m_t;
  bit m_gu;
  logic [4:0] m_bq;

  always #5 clk = ~clk;

  pid_gain_tuner #(
    .GAIN_WIDTH(16), .STEP_FINE(10), .STEP_COARSE(100),
    .KP_INIT(0), .KI_INIT(0), .KD_INIT(0),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_inc_fine(btn[0]), .btn_inc_coarse(btn[1]),
    .btn_dec_fine(btn[2]), .btn_dec_coarse(btn[3]),
    .btn_sel(btn[4]), .lock(lock),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .sel(sel), .gain_updated(gain_updated)
  );

  function automatic void m_apply(int idx);
    int old, v, step;
    step = idx[0] ? 100 : 10;
    old = m_g[m_sel];
    v = idx[1] ? old - step : old + step;
    if (v < 0) v = 0;
    if (v > MAXG) v = MAXG;
    m_g[m_sel] = v;
    m_gu = (v != old);
  endfunction

  // Repeats are timed from the first step: t = DLY, DLY+RATE, ...
  function automatic void m_edge();
    logic [4:0] r;
    m_gu = 1'b0;
    if (reset) begin
      m_g[0] = 0; m_g[1] = 0; m_g[2] = 0;
      m_sel = 0; m_act = -1; m_bq = 5'd0;
      return;
    end
    r = btn & ~m_bq;
    if (m_act >= 0) begin
      if (lock || !btn[m_act]) begin
        m_act = -1;
      end else begin
        m_t++;
        if (m_t == DLY || (m_t > DLY && (m_t - DLY) % RATE == 0))
          m_apply(m_act);
      end
    end else if (!lock) begin
      if (r[3:0] != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (r[i]) m_act = i;
        m_t = 0;
        m_apply(m_act);
      end else if (r[4]) begin
        m_sel = (m_sel + 1) % 3;
      end
    end
    m_bq = btn;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      sbq.push_back({16'(m_g[0]), 16'(m_g[1]), 16'(m_g[2]),
                     2'(m_sel), m_gu});
      #1;
    end
  endtask

  task automatic pulse(logic [4:0] b);
    btn = b;
    tick();
    btn = 5'd0;
    tick();
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [50:0] e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({k_p, k_i, k_d, sel, gain_updated} !== e) begin
        errors++;
        $display("FAIL sb t=%0t: got kp=%0d ki=%0d kd=%0d sel=%0d gu=%0b expected kp=%0d ki=%0d kd=%0d sel=%0d gu=%0b",
                 $time, k_p, k_i, k_d, sel, gain_updated,
                 e[50:35], e[34:19], e[18:3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    m_g[0] = 0; m_g[1] = 0; m_g[2] = 0;
    m_sel = 0; m_act = -1; m_t = 0; m_gu = 0; m_bq = 0;
    #1;
    tick(2);
    reset = 1'b0;
    tick();
    chk("reset_kp", k_p, 0);
    chk("reset_sel", sel, 0);
    chk("reset_gu", gain_updated, 0);

    btn = 5'b00010;
    tick();
    chk("coarse_kp", k_p, 100);
    chk("coarse_gu", gain_updated, 1);
    btn = 5'd0;
    tick();
    chk("coarse_gu_once", gain_updated, 0);

    pulse(5'b10000);
    pulse(5'b10000);
    pulse(5'b00001);
    chk("sel2", sel, 2);
    chk("kd10", k_d, 10);
    chk("kp_hold", k_p, 100);
    pulse(5'b10000);
    chk("sel_wrap", sel, 0);

    reset = 1'b1; tick(); reset = 1'b0;
    btn = 5'b00001;
    tick(21);
    btn = 5'd0;
    tick();
    chk("hold_kp50", k_p, 50);

    reset = 1'b1; tick(); reset = 1'b0;
    pulse(5'b01000);
    chk("dec_clamp0", k_p, 0);
    btn = 5'b00010;
    tick(2700);
    btn = 5'd0;
    tick();
    chk("sat_max", k_p, MAXG);
    pulse(5'b00100);
    chk("near_max", k_p, 65525);
    btn = 5'b00010;
    tick();
    chk("clamp_up", k_p, MAXG);
    chk("clamp_up_gu", gain_updated, 1);
    btn = 5'd0;
    tick();
    pulse(5'b00010);
    btn = 5'b01000;
    tick(2700);
    btn = 5'd0;
    tick();
    chk("sat_min", k_p, 0);

    btn = 5'b01001;
    tick();
    chk("prio_fine", k_p, 10);
    btn = 5'b00001; tick(2);
    btn = 5'b00101; tick();
    btn = 5'b00001; tick(2);
    btn = 5'd0; tick();

    lock = 1'b1;
    for (int i = 0; i < 5; i++) pulse(5'(1 << i));
    pulse(5'b11111);
    lock = 1'b0;
    tick();

    btn = 5'b00001;
    tick(14);
    lock = 1'b1; tick(3);
    lock = 1'b0; tick(12);
    btn = 5'd0; tick();

    btn = 5'b00010;
    tick(14);
    reset = 1'b1; tick();
    chk("rst_kp", k_p, 0);
    chk("rst_sel", sel, 0);
    reset = 1'b0;
    tick(6);
    btn = 5'd0; tick();

    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(39) == 0) lock = ~lock;
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;
    btn = 5'd0;
    tick(2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
